mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all address ports.
REQ-002 Parameter DATA_W, default 32: width of all data ports.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  instruction-fetch request, held until i_rdy.
REQ-006 i_addr  input  ADDR_W  instruction-fetch address.
REQ-007 i_rdy  output  1  the fetch request was accepted by memory this cycle.
REQ-008 i_valid  output  1  the fetch response is valid this cycle.
REQ-009 i_rdata  output  DATA_W  fetch response data.
REQ-010 d_req  input  1  load/store request, held until d_rdy.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  load/store address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_rdy  output  1  the load/store request was accepted this cycle.
REQ-015 d_valid  output  1  the load/store response is valid this cycle.
REQ-016 d_rdata  output  DATA_W  load response data.
REQ-017 flush  input  1  branch/jump redirect; discards any in-flight fetch response.
REQ-018 mem_req  output  1  request to the shared memory port.
REQ-019 mem_we  output  1  write enable to memory.
REQ-020 mem_addr  output  ADDR_W  address to memory.
REQ-021 mem_wdata  output  DATA_W  write data to memory.
REQ-022 mem_rdy  input  1  memory accepted the request this cycle.
REQ-023 mem_valid  input  1  memory completed the transaction this cycle.
REQ-024 mem_rdata  input  DATA_W  memory read data, qualified by mem_valid.

Function
REQ-025 States: IDLE, WAIT_I, WAIT_D; at most one outstanding memory transaction.
REQ-026 IDLE with any request: mem_req=1; mux selects the winner's addr/we/wdata (mem_we=0 and mem_wdata=0 for fetch).
REQ-027 Single requester: that requester wins.
REQ-028 Both requesting: the winner is the port NOT granted last (register last_grant).
REQ-029 Acceptance: winner's rdy = mem_rdy in the same cycle (combinational).
REQ-030 Transitions on acceptance: IDLE->WAIT_I or IDLE->WAIT_D; last_grant updated to the winner.
REQ-031 IDLE with mem_rdy=0: stay in IDLE; re-arbitrate next cycle (requester holds its inputs).
REQ-032 WAIT_x: mem_req=0 and no rdy asserted to either port.
REQ-033 WAIT_x with mem_valid=1: owner's valid=1 and rdata=mem_rdata in the same cycle; next state IDLE.
REQ-034 Earliest next grant is the cycle after mem_valid (no back-to-back overlap).
REQ-035 Non-owner valid=0 always; when not valid, rdata outputs are 0.
REQ-036 discard flag: set by flush while in WAIT_I, or by flush in the cycle of fetch acceptance; cleared when that fetch's mem_valid arrives.
REQ-037 While discard=1: i_valid suppressed (0) on that completion; the state machine still returns to IDLE.
REQ-038 flush in IDLE or WAIT_D: no effect on state; i_req may drop the same cycle.
REQ-039 A store completion raises d_valid with d_rdata=0.
REQ-040 mem_valid in IDLE is ignored: no valid output, no state change.
REQ-041 mem_rdy outside IDLE is ignored.

Reset
REQ-042 rst=0 asynchronously forces state=IDLE, last_grant=instruction, discard=0.
REQ-043 While rst=0 all outputs are 0.
REQ-044 A transaction in flight at reset is abandoned; its later mem_valid is ignored per REQ-040.

Verification
REQ-045 i_req=1, i_addr=0x100, mem_rdy=1 at cycle 0 -> mem_addr=0x100, i_rdy=1 at cycle 0; mem_valid=1, mem_rdata=0x13 at cycle 3 -> i_valid=1, i_rdata=0x13 at cycle 3; d_valid=0 throughout.
REQ-046 After reset, i_req and d_req both held high with mem_rdy=1 -> grant order D, I, D, I across four transactions.
REQ-047 d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_rdy=0 for 2 cycles, then 1 -> mem_req stays 1 with stable mem_addr/mem_wdata; d_rdy only in the third cycle.
REQ-048 Fetch accepted; flush=1 in WAIT_I; mem_valid=1 two cycles later -> i_valid stays 0; state IDLE; the next i_req is granted normally.
REQ-049 rst pulsed low while in WAIT_D, then mem_valid=1 after release -> d_valid=0; state IDLE; last_grant=instruction.
REQ-050 Spurious mem_valid=1 in IDLE with no request -> i_valid=0, d_valid=0; no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the instruction-fetch, load/store and shared-memory handshake signals of the arbiter.
// The slave view belongs to the arbiter; the master view drives requests and models memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rdy;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rdy;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              flush;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, flush,
           mem_rdy, mem_valid, mem_rdata,
    output i_rdy, i_valid, i_rdata, d_rdy, d_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, flush,
           mem_rdy, mem_valid, mem_rdata,
    input  i_rdy, i_valid, i_rdata, d_rdy, d_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port with one outstanding
// transaction, alternating priority on contention and discarding flushed fetch responses.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;

  state_t            state;
  logic              last_grant;
  logic              discard;
  logic              store_q;

  logic              any_req;
  logic              win_d;
  logic              accept;
  logic              done_i;
  logic              done_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Data side wins when it is alone, or when both request and fetch was served last.
  always_comb begin
    any_req   = bus.i_req | bus.d_req;
    win_d     = bus.d_req & (~bus.i_req | (last_grant == GRANT_I));
    accept    = (state == IDLE) & any_req & bus.mem_rdy;
    done_i    = (state == WAIT_I) & bus.mem_valid;
    done_d    = (state == WAIT_D) & bus.mem_valid;
    sel_addr  = win_d ? bus.d_addr : bus.i_addr;
    sel_wdata = (win_d & bus.d_we) ? bus.d_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      discard    <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= win_d ? WAIT_D : WAIT_I;
            last_grant <= win_d;
            store_q    <= win_d & bus.d_we;
            // A redirect in the acceptance cycle already makes this fetch stale.
            discard    <= ~win_d & bus.flush;
          end
        end
        WAIT_I: begin
          if (bus.mem_valid) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (bus.flush) begin
            discard <= 1'b1;
          end
        end
        WAIT_D: begin
          if (bus.mem_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so acceptance and completion land in the same cycle as memory.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_rdy     = 1'b0;
    bus.d_rdy     = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_rdata   = '0;
    bus.d_valid   = 1'b0;
    bus.d_rdata   = '0;
    if (rst) begin
      bus.mem_req = (state == IDLE) & any_req;
      if (bus.mem_req) begin
        bus.mem_we    = win_d & bus.d_we;
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
      end
      bus.i_rdy   = accept & ~win_d;
      bus.d_rdy   = accept & win_d;
      bus.i_valid = done_i & ~discard & ~bus.flush;
      if (bus.i_valid) bus.i_rdata = bus.mem_rdata;
      bus.d_valid = done_d;
      if (done_d & ~store_q) bus.d_rdata = bus.mem_rdata;
    end
  end

endmodule
